// File: rtl/icw_ocw_sequencer.sv
// icw_ocw_sequencer: 8259A ICW/OCW write sequencer; define SEQ_ERROR_EN to build the sticky ignored-write flag
module icw_ocw_sequencer #(
  parameter logic [7:0] IMR_INIT = 8'h00,
  parameter logic READ_SEL_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_stb,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       init_done,
  output logic [4:0] vector_base,
  output logic       ltim,
  output logic       sngl,
  output logic       ic4,
  output logic [7:0] cascade_cfg,
  output logic       aeoi,
  output logic       upm,
  output logic [1:0] buf_ms,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       ocw2_stb,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       read_sel,
  output logic       smm,
  output logic       poll_stb,
  output logic       seq_error
);
  typedef enum logic [2:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
  state_t state;
  logic icw1;
  assign icw1 = !a0 && din[4];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      init_done <= 1'b0;
      vector_base <= '0;
      ltim <= 1'b0;
      sngl <= 1'b0;
      ic4 <= 1'b0;
      cascade_cfg <= '0;
      aeoi <= 1'b0;
      upm <= 1'b0;
      buf_ms <= '0;
      sfnm <= 1'b0;
      imr <= IMR_INIT;
      ocw2_stb <= 1'b0;
      ocw2_cmd <= '0;
      ocw2_level <= '0;
      read_sel <= READ_SEL_INIT;
      smm <= 1'b0;
      poll_stb <= 1'b0;
    end else begin
      ocw2_stb <= 1'b0;
      poll_stb <= 1'b0;
      if (wr_stb && icw1) begin
        ltim <= din[3];
        sngl <= din[1];
        ic4 <= din[0];
        imr <= IMR_INIT;
        read_sel <= READ_SEL_INIT;
        smm <= 1'b0;
        aeoi <= 1'b0;
        upm <= 1'b0;
        sfnm <= 1'b0;
        buf_ms <= '0;
        init_done <= 1'b0;
        state <= WAIT_ICW2;
      end else if (wr_stb)
        case (state)
          WAIT_ICW2:
            if (a0) begin
              vector_base <= din[7:3];
              state <= !sngl ? WAIT_ICW3 : ic4 ? WAIT_ICW4 : READY;
              init_done <= sngl && !ic4;
            end
          WAIT_ICW3:
            if (a0) begin
              cascade_cfg <= din;
              state <= ic4 ? WAIT_ICW4 : READY;
              init_done <= !ic4;
            end
          WAIT_ICW4:
            if (a0) begin
              sfnm <= din[4];
              buf_ms <= din[3:2];
              aeoi <= din[1];
              upm <= din[0];
              state <= READY;
              init_done <= 1'b1;
            end
          READY:
            if (a0)
              imr <= din;
            else if (!din[3]) begin
              ocw2_cmd <= din[7:5];
              ocw2_level <= din[2:0];
              ocw2_stb <= 1'b1;
            end else begin
              read_sel <= din[1] ? din[0] : read_sel;
              smm <= din[6] ? din[5] : smm;
              poll_stb <= din[2];
            end
          default: ;
        endcase
    end
`ifdef SEQ_ERROR_EN
  logic ignored;
  assign ignored = wr_stb && !icw1 && (state == IDLE || (state != READY && !a0));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      seq_error <= 1'b0;
    else
      seq_error <= (wr_stb && icw1) ? 1'b0 : (seq_error || ignored);
`else
  assign seq_error = 1'b0;
`endif
endmodule

// File: doc/icw_ocw_sequencer.md
Name: icw_ocw_sequencer

Overview:
- Downstream consumer of the 8259A bus control logic.
- Takes one write per strobe (A0 plus the 8-bit internal data bus) and runs the ICW1→ICW2→[ICW3]→[ICW4] initialization state machine.
- Resolves the A0=1 ambiguity between ICW2/ICW3/ICW4 and OCW1 by sequence state.
- Holds the resulting configuration, mask and read-select registers. Issues one-cycle OCW2 and poll command pulses to the priority/ISR logic.

Parameters:
- IMR_INIT, 8'h00, IMR value loaded at reset and on every ICW1.
- READ_SEL_INIT, 1'b0, read-register select loaded at reset and on ICW1 (0=IRR, 1=ISR).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_stb  in  1  one-cycle write strobe from bus control logic, synchronous to clk
- a0  in  1  address bit A0 qualified with wr_stb
- din  in  8  internal data bus value qualified with wr_stb
- init_done  out  1  high in READY state
- vector_base  out  5  ICW2 T7..T3
- ltim  out  1  ICW1 D3, level-triggered mode
- sngl  out  1  ICW1 D1, single mode
- ic4  out  1  ICW1 D0, ICW4 expected
- cascade_cfg  out  8  ICW3 byte
- aeoi  out  1  ICW4 D1
- upm  out  1  ICW4 D0, 8086 mode
- buf_ms  out  2  ICW4 D3..D2
- sfnm  out  1  ICW4 D4
- imr  out  8  interrupt mask register (OCW1)
- ocw2_stb  out  1  one-cycle pulse per OCW2
- ocw2_cmd  out  3  OCW2 R/SL/EOI (D7..D5), held until next OCW2
- ocw2_level  out  3  OCW2 L2..L0, held until next OCW2
- read_sel  out  1  0=IRR, 1=ISR for status reads
- smm  out  1  special mask mode
- poll_stb  out  1  one-cycle pulse on OCW3 with P=1
- seq_error  out  1  sticky ignored-write flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, except imr=IMR_INIT and read_sel=READ_SEL_INIT.
- Write sampling and latency:
  - A write is any cycle with wr_stb=1 at the rising edge. Consecutive high cycles count as separate writes.
  - Register updates and pulses appear the cycle after the sampled write (1-cycle latency).
- ICW1 (a0=0, din[4]=1) is accepted in any state, including mid-init and READY:
  - ltim=din[3], sngl=din[1], ic4=din[0].
  - imr=IMR_INIT, read_sel=READ_SEL_INIT, smm=0.
  - aeoi=upm=sfnm=0, buf_ms=0.
  - init_done=0, next state WAIT_ICW2.
  - vector_base and cascade_cfg keep their old values until rewritten.
- IDLE: every non-ICW1 write is ignored.
- WAIT_ICW2:
  - a0=1 → vector_base=din[7:3].
  - Next state: WAIT_ICW3 if sngl=0; else WAIT_ICW4 if ic4=1; else READY.
- WAIT_ICW3:
  - a0=1 → cascade_cfg=din.
  - Next state: WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW4:
  - a0=1 → sfnm=din[4], buf_ms=din[3:2], aeoi=din[1], upm=din[0].
  - Next state: READY.
- In any WAIT_* state, an a0=0 write that is not ICW1 is ignored and the state is held.
- READY:
  - a0=1 → OCW1: imr=din.
  - a0=0, din[4:3]=00 → OCW2: ocw2_cmd=din[7:5], ocw2_level=din[2:0], ocw2_stb=1 for exactly one cycle.
  - a0=0, din[4:3]=01 → OCW3:
    - if din[1] (RR), read_sel=din[0];
    - if din[6] (ESMM), smm=din[5];
    - if din[2] (P), poll_stb=1 for one cycle.
    - An OCW3 with RR=0 and ESMM=0 changes neither read_sel nor smm.
- Pulses: ocw2_stb and poll_stb are never high in two consecutive cycles unless two writes are sampled back-to-back.
- Reset mid-operation: asynchronous return to IDLE with reset values; any pending pulse is dropped.

Optional Feature:
- Macro SEQ_ERROR_EN.
- Defined:
  - seq_error is set (sticky) on any ignored write: a non-ICW1 write in IDLE, or an a0=0 non-ICW1 write in a WAIT_* state.
  - Cleared by ICW1 and by reset; visible the cycle after the offending write.
- Undefined: seq_error is tied to 0 and no error logic is built.

Test Plan:
- Reset → init_done=0, imr=8'h00, read_sel=0. Then a0=0, din=8'h1B (ICW1, LTIM=1, SNGL=1, IC4=1) → state WAIT_ICW2, ltim=1, sngl=1, ic4=1.
- Full cascade init:
  - ICW1 din=8'h11, ICW2 din=8'h40, ICW3 din=8'h04, ICW4 din=8'h03.
  - → vector_base=5'h08, cascade_cfg=8'h04, aeoi=1, upm=1, init_done=1 one cycle after the ICW4 write.
- Single mode without ICW4: ICW1 din=8'h12, ICW2 din=8'hF8 → init_done=1 right after ICW2, vector_base=5'h1F, aeoi=0.
- READY command writes:
  - a0=1 din=8'hA5 → imr=8'hA5.
  - a0=0 din=8'h63 → ocw2_stb high exactly one cycle, ocw2_cmd=3'b011, ocw2_level=3'd3.
  - a0=0 din=8'h0B → read_sel=1.
  - a0=0 din=8'h6C → smm=1, poll_stb one-cycle pulse.
- Re-init and abort:
  - ICW1 during READY with imr=8'hA5 → imr=8'h00, init_done=0.
  - rst_n low during WAIT_ICW3 → IDLE; a following a0=1 write is ignored, and seq_error=1 when SEQ_ERROR_EN is defined.
- Ignored write mid-init: in WAIT_ICW2, a0=0 din=8'h20 → no state change and no ocw2_stb. seq_error=1 with SEQ_ERROR_EN; a subsequent ICW1 clears it.
